// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch with single-outstanding imem handshake,
// one-entry decode-stall hold buffer and execute-stage redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        StallD_i,
    input  logic        FlushD_i,
    input  logic        PCSrcE_i,
    input  logic [31:0] PCTargetE_i,
    output logic [31:0] InstrD_o,
    output logic [31:0] PCD_o,
    output logic [31:0] PCPlus4D_o,
    output logic        ValidD_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic        kill_q, kill_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instrd_q, instrd_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4d_q, pcp4d_d;
    logic        validd_q, validd_d;
    logic        rsp_take, load_rsp, load_buf, squash;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            pcf_q        <= RESET_PC;
            kill_q       <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= 32'h0;
            instrd_q     <= NOP_INSTR;
            pcd_q        <= 32'h0;
            pcp4d_q      <= 32'h0;
            validd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instrd_q     <= instrd_d;
            pcd_q        <= pcd_d;
            pcp4d_q      <= pcp4d_d;
            validd_q     <= validd_d;
        end
    end

    // A response is usable only when it belongs to the current (non-killed) path
    assign rsp_take = (state_q == WAIT) && imem_rvalid_i && !kill_q;
    assign load_rsp = rsp_take && !StallD_i;
    assign load_buf = (state_q == HOLD) && !StallD_i;
    assign squash   = PCSrcE_i || FlushD_i;

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: if (imem_gnt_i) begin
                state_d = WAIT;
                kill_d  = PCSrcE_i;
            end
            WAIT: if (imem_rvalid_i) begin
                kill_d  = 1'b0;
                state_d = (kill_q || PCSrcE_i || !StallD_i) ? REQ : HOLD;
            end else if (PCSrcE_i) begin
                kill_d = 1'b1;
            end
            HOLD: if (PCSrcE_i || !StallD_i) state_d = REQ;
        endcase
    end

    always_comb begin
        pcf_d        = PCSrcE_i ? (PCTargetE_i & ~32'h3) : rsp_take ? pcf_q + 32'd4 : pcf_q;
        hold_instr_d = (rsp_take && StallD_i && !PCSrcE_i) ? imem_rdata_i : hold_instr_q;
        hold_pc_d    = (rsp_take && StallD_i && !PCSrcE_i) ? pcf_q : hold_pc_q;
        instrd_d     = squash ? NOP_INSTR : load_rsp ? imem_rdata_i : load_buf ? hold_instr_q : instrd_q;
        pcd_d        = squash ? 32'h0 : load_rsp ? pcf_q : load_buf ? hold_pc_q : pcd_q;
        pcp4d_d      = squash ? 32'h0 : load_rsp ? pcf_q + 32'd4 : load_buf ? hold_pc_q + 32'd4 : pcp4d_q;
        validd_d     = squash ? 1'b0 : (load_rsp || load_buf) ? 1'b1 : validd_q;
    end

    always_comb begin
        imem_req_o  = (state_q == REQ);
        imem_addr_o = pcf_q;
        InstrD_o    = instrd_q;
        PCD_o       = pcd_q;
        PCPlus4D_o  = pcp4d_q;
        ValidD_o    = validd_q;
    end
endmodule
